// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with tenure limit and one-cycle turnaround
module bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_TENURE = 8,
  localparam int SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic [SEL_WIDTH-1:0]          sel,
  output logic                          bus_valid,
  output logic [DATA_WIDTH-1:0]         data_out
);

  localparam int TEN_W = $clog2(MAX_TENURE + 2);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic [TEN_W-1:0]     ten_q, ten_d;
  logic                 bus_valid_q, bus_valid_d;

  logic                 win_found;
  logic [SEL_WIDTH-1:0] win_idx;
  logic [SEL_WIDTH-1:0] cand;
  logic                 preempt;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    // Scan from farthest to nearest so the source just after last_q wins;
    // offset NUM_REQ wraps to last_q itself, giving the old owner lowest priority.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = last_q + SEL_WIDTH'(off);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign preempt = (MAX_TENURE != 0) && (ten_q == TEN_W'(MAX_TENURE)) &&
                   (|(req & ~grant_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    ten_d   = ten_q;
    case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        if (win_found) begin
          state_d = GRANT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_d   = win_idx;
          last_d  = win_idx;
          ten_d   = TEN_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!req[sel_q] || preempt) begin
          state_d = TURN;
          grant_d = '0;
        end else if (ten_q < TEN_W'(MAX_TENURE)) begin
          ten_d = ten_q + TEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    bus_valid_d = |grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= SEL_WIDTH'(NUM_REQ - 1);
      ten_q       <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      ten_q       <= ten_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign bus_valid = bus_valid_q;
  assign data_out  = bus_valid_q ? data_in[sel_q*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and random checks of bus_arbiter against a reference model
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BOUND = (N - 1) * (8 + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  g8, g0;
  logic [1:0]    s8, s0;
  logic          v8, v0;
  logic [DW-1:0] d8, d0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_TENURE(8)) u8 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(g8), .sel(s8), .bus_valid(v8), .data_out(d8));

  bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_TENURE(0)) u0 (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(g0), .sel(s0), .bus_valid(v0), .data_out(d0));

  int n_vec = 0;
  int n_fail = 0;

  // Model state per instance: index 0 is MAX_TENURE=8, index 1 is MAX_TENURE=0.
  int m_own[2];
  int m_last[2];
  int m_ten[2];
  int m_sel[2];
  int maxt[2] = '{8, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [N-1:0] r);
    for (int off = 1; off <= N; off++)
      if (r[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_own[m] = -1; m_last[m] = N - 1; m_ten[m] = 0; m_sel[m] = 0;
    end
  endtask

  // An owner ends its tenure on release or on preemption, which leaves one idle
  // cycle; any cycle with no owner arbitrates, so the dead cycle falls out naturally.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (m_own[m] >= 0) begin
        logic [N-1:0] others;
        bit pre;
        others = req & ~(N'(1) << m_own[m]);
        pre = (maxt[m] != 0) && (m_ten[m] == maxt[m]) && (others != 0);
        if (!req[m_own[m]] || pre) m_own[m] = -1;
        else if (m_ten[m] < maxt[m]) m_ten[m]++;
      end else begin
        int w;
        w = pick(m_last[m], req);
        if (w >= 0) begin
          m_own[m] = w; m_last[m] = w; m_sel[m] = w; m_ten[m] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0]  eg, og;
      logic [DW-1:0] ed, od;
      logic [1:0]    os;
      logic          ov;
      eg = (m_own[m] >= 0) ? N'(1) << m_own[m] : '0;
      ed = (m_own[m] >= 0) ? data_in[m_own[m]*DW +: DW] : '0;
      og = (m == 0) ? g8 : g0;
      os = (m == 0) ? s8 : s0;
      ov = (m == 0) ? v8 : v0;
      od = (m == 0) ? d8 : d0;
      chk($sformatf("grant%0d", m), 32'(og), 32'(eg));
      chk($sformatf("sel%0d", m), 32'(os), 32'(m_sel[m]));
      chk($sformatf("bus_valid%0d", m), 32'(ov), 32'(eg != 0));
      chk($sformatf("data_out%0d", m), 32'(od), 32'(ed));
      chk($sformatf("onehot%0d", m), 32'($countones(og) <= 1), 32'd1);
      chk($sformatf("sel_index%0d", m), 32'(!ov || (og == (N'(1) << os))), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    req = r;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  int hold;
  logic [N-1:0] prev;
  logic [N-1:0] seq[$];
  logic [N-1:0] exp_seq[9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0001};
  int cnt;
  int wait_c[N];
  int max_wait;

  initial begin
    reset = 1'b1;
    req = '0;
    data_in = 32'hDDCCBBAA;

    // Reset with all requesting, source 0 wins first.
    do_reset(4'b1111);
    tick();
    chk("t1_grant", 32'(g8), 32'h1);
    chk("t1_sel", 32'(s8), 32'h0);
    chk("t1_data", 32'(d8), 32'hAA);

    // Round robin, each owner holds 3 cycles.
    do_reset(4'b1111);
    hold = 0;
    prev = '0;
    for (int i = 0; i < 60 && seq.size() < 9; i++) begin
      tick();
      if (g0 != prev && (seq.size() > 0 || g0 != 0)) seq.push_back(g0);
      prev = g0;
      if (m_own[1] >= 0) hold++; else hold = 0;
      req = (hold == 3) ? (4'b1111 & ~(N'(1) << m_own[1])) : 4'b1111;
      data_in = $urandom;
    end
    chk("t2_seq_len", 32'(seq.size()), 32'd9);
    for (int k = 0; k < seq.size() && k < 9; k++)
      chk($sformatf("t2_seq%0d", k), 32'(seq[k]), 32'(exp_seq[k]));

    // Preemption at the tenure limit.
    do_reset(4'b0100);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (g8 == 4'b0100) cnt++;
      else break;
      if (cnt == 5) req = 4'b0101;
    end
    chk("t3_tenure", 32'(cnt), 32'd8);
    chk("t3_dead", 32'(g8), 32'h0);
    tick();
    chk("t3_next", 32'(g8), 32'h1);

    // Sole requester keeps the bus.
    do_reset(4'b0010);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold", 32'(g8), 32'h2);
    end

    // Release and new request in the same cycle.
    do_reset(4'b0010);
    repeat (3) tick();
    req = 4'b1000;
    tick();
    chk("t5_turn_valid", 32'(v8), 32'h0);
    tick();
    chk("t5_grant", 32'(g8), 32'h8);
    chk("t5_sel", 32'(s8), 32'h3);

    // Asynchronous reset mid-tenure.
    do_reset(4'b0100);
    repeat (3) tick();
    chk("t6_owner", 32'(g8), 32'h4);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_async_grant", 32'(g8), 32'h0);
    check_all();
    @(negedge clk);
    req = 4'b0101;
    reset = 1'b0;
    tick();
    chk("t6_ptr", 32'(g8), 32'h1);

    // Random soak with starvation bound on the preempting instance.
    do_reset(4'b0000);
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req[i] && !g8[i]) wait_c[i]++; else wait_c[i] = 0;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      data_in = $urandom;
    end
    chk("soak_starvation", 32'(max_wait <= BOUND), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
